ex_hazard_ctrl: RTL and testbench

//  Pipeline controller for the Execute stage: owns the forwarding selects ForwardDa/ForwardDb and the stall/flush/hold controls.

---
 rtl/ex_ctrl_pkg.sv | 42 ++++
 rtl/hazard_slot_pipe.sv | 28 ++
 rtl/ex_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ex_ctrl_pkg.sv
// Shared types and helpers for the Execute-stage hazard controller.
package ex_ctrl_pkg;

  localparam int unsigned SLOT_RD_W = 5;
  localparam logic [SLOT_RD_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MULWAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
    logic                 ismul;
  } slot_t;

  // Forwarding select for one source register; the Ex producer wins over Mem.
  function automatic fwd_sel_t fwd_pick(input logic [SLOT_RD_W-1:0] r,
                                        input logic                 used,
                                        input logic [SLOT_RD_W-1:0] zero,
                                        input slot_t                ex,
                                        input slot_t                mem);
    fwd_pick = FWD_REG;
    if (used && (r != zero)) begin
      if (ex.valid && ex.regwrite && (ex.rd == r)) begin
        fwd_pick = FWD_MEM;
      end else if (mem.valid && mem.regwrite && (mem.rd == r)) begin
        fwd_pick = FWD_WB;
      end
    end
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Shadow pipe of destination-register info for the Ex and Mem slots.
// The Wb slot is not stored: Wb matches are never forwarded or stalled on,
// since the register file writes before it reads.
module hazard_slot_pipe
  import ex_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  slot_t id_slot,
  output slot_t ex_slot,
  output slot_t mem_slot
);

  // Advance ID -> Ex -> Mem each cycle; on hold keep Ex and bubble Mem.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else if (hold) begin
      mem_slot <= '0;
    end else begin
      ex_slot  <= id_slot;
      mem_slot <= ex_slot;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage pipeline controller: forwarding selects, load-use stall,
// branch squash and multi-cycle MUL hold sequencing.
module ex_hazard_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned MUL_LAT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IdValid,
  input  logic [REG_W-1:0] IdRa,
  input  logic [REG_W-1:0] IdRb,
  input  logic             IdUsesRa,
  input  logic             IdUsesRb,
  input  logic [REG_W-1:0] IdRd,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic             IdIsMul,
  input  logic             ExBrTaken,
  output logic [1:0]       ForwardDa,
  output logic [1:0]       ForwardDb,
  output logic             PCWrite,
  output logic             IfIdWrite,
  output logic             IfIdFlush,
  output logic             IdExFlush,
  output logic             ExHold,
  output logic             MemBubble
);

  localparam int unsigned     CNT_W = $clog2(MUL_LAT) + 1;
  localparam logic [REG_W-1:0] ZR   = REG_W'(ZERO_REG);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  slot_t            id_slot, ex_slot, mem_slot;
  fwd_sel_t         fwd_a, fwd_b;
  logic             load_use;

  hazard_slot_pipe u_slots (
    .clk      (clk),
    .reset    (reset),
    .hold     (ExHold),
    .id_slot  (id_slot),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot)
  );

  // Slot presented by ID; becomes a bubble when squashed or empty.
  always_comb begin
    id_slot          = '0;
    id_slot.valid    = IdValid && !IdExFlush;
    id_slot.rd       = IdRd;
    id_slot.regwrite = IdRegWrite;
    id_slot.memread  = IdMemRead;
    id_slot.ismul    = IdIsMul;
  end

  // Load in Ex feeding a used ID source (masked while a MUL is held).
  always_comb begin
    load_use = (state == RUN) && IdValid && ex_slot.valid && ex_slot.memread &&
               (ex_slot.rd != ZR) &&
               ((IdUsesRa && (IdRa == ex_slot.rd)) ||
                (IdUsesRb && (IdRb == ex_slot.rd)));
  end

  // Next state, MUL wait counter and pipeline control outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    PCWrite   = 1'b1;
    IfIdWrite = 1'b1;
    IfIdFlush = 1'b0;
    IdExFlush = 1'b0;
    ExHold    = 1'b0;
    MemBubble = 1'b0;
    case (state)
      RUN: begin
        if (ExBrTaken) begin
          IfIdFlush = 1'b1;
          IdExFlush = 1'b1;
        end else if (load_use) begin
          PCWrite   = 1'b0;
          IfIdWrite = 1'b0;
          IdExFlush = 1'b1;
        end
        // Enter the wait on the edge the MUL lands in Ex, so the RUN cycle
        // that follows the wait (MUL still in Ex) does not re-trigger it.
        if (IdValid && IdIsMul && !IdExFlush && (MUL_LAT > 1)) begin
          state_nxt = MULWAIT;
          cnt_nxt   = CNT_W'(MUL_LAT - 2);
        end
      end
      MULWAIT: begin
        ExHold    = 1'b1;
        MemBubble = 1'b1;
        PCWrite   = 1'b0;
        IfIdWrite = 1'b0;
        if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Forwarding selects for the instruction entering Ex; bubbles get 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
    end else if (!ExHold) begin
      if (id_slot.valid) begin
        fwd_a <= fwd_pick(IdRa, IdUsesRa, ZR, ex_slot, mem_slot);
        fwd_b <= fwd_pick(IdRb, IdUsesRb, ZR, ex_slot, mem_slot);
      end else begin
        fwd_a <= FWD_REG;
        fwd_b <= FWD_REG;
      end
    end
  end

  assign ForwardDa = fwd_a;
  assign ForwardDb = fwd_b;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: table of per-cycle vectors plus
// hand-written MUL hold sequences.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       IdValid, IdUsesRa, IdUsesRb, IdRegWrite, IdMemRead, IdIsMul, ExBrTaken;
  logic [4:0] IdRa, IdRb, IdRd;
  logic [1:0] ForwardDa, ForwardDb;
  logic       PCWrite, IfIdWrite, IfIdFlush, IdExFlush, ExHold, MemBubble;

  int checks = 0;
  int failures = 0;

  // Expected output word: {fa[1:0], fb[1:0], pcw, ifw, iff, ief, hold, mb}
  localparam logic [9:0] E_IDLE = 10'b00_00_1100_00;
  localparam logic [9:0] E_STAL = 10'b00_00_0001_00;
  localparam logic [9:0] E_BRCH = 10'b00_00_1111_00;
  localparam logic [9:0] E_HOLD = 10'b00_00_0000_11;
  localparam logic [9:0] E_FA1  = 10'b01_00_1100_00;
  localparam logic [9:0] E_FB2  = 10'b00_10_1100_00;
  localparam logic [9:0] E_F22  = 10'b10_10_1100_00;

  typedef struct {
    bit         rst;
    string      name;
    logic       v;
    logic [4:0] ra;
    logic       ua;
    logic [4:0] rb;
    logic       ub;
    logic [4:0] rd;
    logic       rw, mr, mul, br;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  ex_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .MUL_LAT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .IdValid    (IdValid),
    .IdRa       (IdRa),
    .IdRb       (IdRb),
    .IdUsesRa   (IdUsesRa),
    .IdUsesRb   (IdUsesRb),
    .IdRd       (IdRd),
    .IdRegWrite (IdRegWrite),
    .IdMemRead  (IdMemRead),
    .IdIsMul    (IdIsMul),
    .ExBrTaken  (ExBrTaken),
    .ForwardDa  (ForwardDa),
    .ForwardDb  (ForwardDb),
    .PCWrite    (PCWrite),
    .IfIdWrite  (IfIdWrite),
    .IfIdFlush  (IfIdFlush),
    .IdExFlush  (IdExFlush),
    .ExHold     (ExHold),
    .MemBubble  (MemBubble)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit rst, input string name, input logic v,
                              input logic [4:0] ra, input logic ua,
                              input logic [4:0] rb, input logic ub,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic mul, input logic br, input logic [9:0] exp);
    vec_t t;
    t.rst = rst; t.name = name; t.v = v; t.ra = ra; t.ua = ua; t.rb = rb; t.ub = ub;
    t.rd = rd; t.rw = rw; t.mr = mr; t.mul = mul; t.br = br; t.exp = exp;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    IdValid = t.v; IdRa = t.ra; IdUsesRa = t.ua; IdRb = t.rb; IdUsesRb = t.ub;
    IdRd = t.rd; IdRegWrite = t.rw; IdMemRead = t.mr; IdIsMul = t.mul; ExBrTaken = t.br;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {ForwardDa, ForwardDb, PCWrite, IfIdWrite, IfIdFlush, IdExFlush, ExHold, MemBubble};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b (fa fb pcw ifw iff ief hold mb)", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives, compares at negedge, returns at next posedge+1.
  task automatic apply(input vec_t t);
    drive(t);
    @(negedge clk);
    check(t.name, t.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(mk(0, "", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    //        rst name         v  ra  ua rb  ub rd  rw mr mul br exp
    // 1: back-to-back ALU dependency -> Da from Mem ALU output
    tbl.push_back(mk(1, "t1_add_x1",  1,  2, 1,  3, 1,  1, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t1_add_x4",  1,  1, 1,  5, 1,  4, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t1_fwd_da1", 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_FA1));
    // 2a: producer two ahead -> Db from Wb
    tbl.push_back(mk(1, "t2_add_x1",  1,  2, 1,  3, 1,  1, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t2_nop",     0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t2_sub",     1,  7, 1,  1, 1,  6, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t2_fwd_db2", 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_FB2));
    // 2b: producers in both Ex and Mem -> Ex wins
    tbl.push_back(mk(1, "t2b_add_a",  1,  2, 1,  3, 1,  1, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t2b_add_b",  1,  2, 1,  3, 1,  1, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t2b_use",    1,  1, 1,  9, 1,  6, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t2b_prio",   0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_FA1));
    // 3: load-use -> one stall cycle, then both from Wb
    tbl.push_back(mk(1, "t3_ldur_x4", 1,  0, 1,  0, 0,  4, 1, 1, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t3_stall",   1,  4, 1,  4, 1,  5, 1, 0, 0, 0, E_STAL));
    tbl.push_back(mk(0, "t3_retry",   1,  4, 1,  4, 1,  5, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t3_fwd22",   0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_F22));
    // 4: XZR never forwarded, never stalls
    tbl.push_back(mk(1, "t4_add_x31", 1,  2, 1,  3, 1, 31, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t4_use_x31", 1, 31, 1, 31, 1,  2, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t4_ldur_31", 1,  0, 1,  0, 0, 31, 1, 1, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t4_nostall", 1, 31, 1, 31, 1,  7, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t4_fwd0",    0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_IDLE));
    // 5: taken branch overrides load-use stall
    tbl.push_back(mk(1, "t5_ldur_x4", 1,  0, 1,  0, 0,  4, 1, 1, 0, 0, E_IDLE));
    tbl.push_back(mk(0, "t5_branch",  1,  4, 1,  4, 1,  5, 1, 0, 0, 1, E_BRCH));
    tbl.push_back(mk(0, "t5_after",   0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_IDLE));

    do_reset();
    check("reset_vals", E_IDLE);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i]);
    end

    // 6: MUL X8 with 3 hold cycles, then dependent ADD gets Da from Mem ALU
    do_reset();
    apply(mk(0, "t6_mul_x8",  1,  9, 1, 10, 1,  8, 1, 0, 1, 0, E_IDLE));
    for (int unsigned k = 0; k < 3; k++)
      apply(mk(0, $sformatf("t6_hold%0d", k + 1), 1, 8, 1, 12, 1, 11, 1, 0, 0, 0, E_HOLD));
    apply(mk(0, "t6_release", 1,  8, 1, 12, 1, 11, 1, 0, 0, 0, E_IDLE));
    apply(mk(0, "t6_fwd_da1", 0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_FA1));

    // 6b: reset during the 2nd hold cycle abandons the wait
    do_reset();
    apply(mk(0, "t6r_mul_x8", 1,  9, 1, 10, 1,  8, 1, 0, 1, 0, E_IDLE));
    apply(mk(0, "t6r_hold1",  1,  8, 1, 12, 1, 11, 1, 0, 0, 0, E_HOLD));
    reset = 1'b1;
    apply(mk(0, "t6r_hold2",  1,  8, 1, 12, 1, 11, 1, 0, 0, 0, E_HOLD));
    reset = 1'b0;
    apply(mk(0, "t6r_reset",  0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_IDLE));
    apply(mk(0, "t6r_stay",   0,  0, 0,  0, 0,  0, 0, 0, 0, 0, E_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
